board_row_snapshot: RTL
=======================

# board_row_snapshot

Downstream consumer of the game-board memory's row read port. On a `start` pulse it sweeps all board rows through the `GET_ROW` interface, captures each row's occupancy into a double-buffered shadow array, and flags completely filled lines. It then atomically swaps the captured frame to the display side. The display renderer reads pixels from the stable front buffer. The game controller consumes the full-line mask and issues `REMOVE_LINE`.

## Interface
Parameters:
- `ROWS`, 20: board rows scanned, indices 0..ROWS-1
- `COLS`, 10: board columns, taken from `row_data[COLS-1:0]`
- `ROW_W`, 32: width of the memory row status word
- `MEM_LAT`, 2: cycles from `row_req`/`row_idx` presented to valid `row_data`; must be at least 1

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  request a full board sweep; single-cycle pulse
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle pulse; new frame visible
- `row_req`  out  1  GET_ROW strobe to board memory
- `row_idx`  out  5  row index to memory `get_line_num`
- `row_data`  in  ROW_W  row status from memory
- `rd_row`  in  5  display read row
- `rd_col`  in  4  display read column
- `rd_pix`  out  1  occupancy of (`rd_row`, `rd_col`) in the front buffer; registered
- `full_mask`  out  ROWS  bit r set when row r was completely filled in the last frame
- `full_valid`  out  1  `full_mask` holds an unacknowledged result
- `full_ack`  in  1  controller has consumed `full_mask`
- `frame_id`  out  1  toggles on every buffer swap

## Operation
FSM states are IDLE, SCAN, DRAIN and SWAP.

**IDLE**
- `start` moves the FSM to SCAN.
- Entering SCAN clears the issue counter and the accumulating mask.
- `start` is ignored in every other state.

**SCAN**
- `row_req` is 1 and `row_idx` equals the issue counter.
- The counter increments every cycle.
- After row ROWS-1 is issued, the FSM moves to DRAIN.

**Capture pipeline**
- An MEM_LAT-deep shift register carries a valid bit and the row index alongside each request.
- When the tail entry is valid, the block writes `row_data[COLS-1:0]` into back-buffer row `idx`.
- At the same time, it sets `mask_acc[idx]` equal to the AND-reduction of `row_data[COLS-1:0]`.
- Bits of `row_data` at and above COLS are ignored.

**DRAIN**
- The FSM waits until the pipeline is empty, then moves to SWAP.

**SWAP**
- Lasts one cycle.
- At its closing edge:
  - the front/back bank select flips;
  - `frame_id` toggles;
  - `full_mask` loads `mask_acc`;
  - `full_valid` is set to 1;
  - `done` is set for one cycle.
- The FSM then returns to IDLE.

**`full_valid` handshake**
- `full_ack` clears `full_valid` and leaves `full_mask` unchanged.
- If a new SWAP coincides with `full_ack`, or `full_valid` is still high at the swap, the new mask overwrites the old one and `full_valid` stays 1. The publish wins.

**Display read**
- `rd_pix` is registered and reads from the front buffer only.
- It returns 0 when `rd_row` is at least ROWS or `rd_col` is at least COLS.

**Busy**
- `busy` is 1 in SCAN, DRAIN and SWAP, and 0 in IDLE.

**Reset**
- Clears both banks to 0 and the pipeline valid bits.
- Bank select goes to 0; FSM goes to IDLE.
- A reset mid-sweep discards the partial frame. The front buffer reads 0 afterwards.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high.
- `row_req` is high in cycles 1..ROWS, with `row_idx` = cycle-1.
- Row r data is sampled at the end of cycle r+1+MEM_LAT.
- SWAP occupies cycle ROWS+MEM_LAT+1.
- `done`, the new `full_mask`, `full_valid`=1, the toggled `frame_id` and new-frame `rd_pix` are all first visible in cycle ROWS+MEM_LAT+2. With default parameters this is cycle 24.
- Back-to-back sweeps: the earliest accepted `start` is the `done` cycle.
- `rd_pix` latency is 1 cycle from `rd_row`/`rd_col`.
- Reset values of all outputs are 0: `busy`, `done`, `row_req`, `row_idx`, `rd_pix`, `full_mask`, `full_valid`, `frame_id`.

## Structure
- Shared package `board_pkg` contains:
  - board geometry constants ROWS=20 and COLS=10;
  - instruction opcodes REMOVE_LINE 6'b011101, MOV_LEFT 6'b011010, MOV_RIGHT 6'b011011, MOV_DOWN 6'b011100, NEW_SHAPE 6'b011001, GET_ROW 6'b011111;
  - the scanner state enum.
- Sub-module `row_buffer`: a two-bank ROWS×COLS register array. It has one write port (bank, row, data), one registered read port (bank, row, col), and an asynchronous clear.

## Test plan
- **Reset, then read:** assert `rst` mid-sweep at cycle 5 -> all outputs 0, `busy`=0, and `rd_pix`=0 for every (row, col).
- **Single sweep with MEM_LAT=2:** memory model returns row r as `32'h3FF` for r=0 and r=7, and `32'h155` otherwise -> `done` in cycle 24, `full_mask`=20'h00081, `full_valid`=1, `rd_pix`(7,9)=1, `rd_pix`(3,1)=0.
- **Ignored restart:** `start` re-pulsed in cycles 3 and 15 -> no extra `row_req`, exactly 20 requests issued, one `done`.
- **Ack and publish collision:** `full_ack` is asserted in the same cycle as the second sweep's SWAP edge -> `full_valid` stays 1 and `full_mask` takes the second frame's value.
- **Frame stability:** during the second sweep (all rows `32'h0`), continuously read (0,0) -> the first frame's value is returned until the `done` cycle, then 0; `frame_id` toggles exactly once.
- **Out of range and upper bits:** `rd_row`=20 or `rd_col`=10 -> `rd_pix`=0. `row_data`=`32'hFFFFFC00` -> row captured as 0 and its mask bit is 0.

Source files
------------

// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared board geometry, instruction opcodes and row scanner state
// Contents:
//   ROWS, COLS      board geometry
//   opcode values   board memory instruction set
//   scan_state_t    row snapshot scanner states
package board_pkg;

    localparam int ROWS = 20;
    localparam int COLS = 10;

    localparam logic [5:0] NEW_SHAPE   = 6'b011001;
    localparam logic [5:0] MOV_LEFT    = 6'b011010;
    localparam logic [5:0] MOV_RIGHT   = 6'b011011;
    localparam logic [5:0] MOV_DOWN    = 6'b011100;
    localparam logic [5:0] REMOVE_LINE = 6'b011101;
    localparam logic [5:0] GET_ROW     = 6'b011111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_SWAP  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/row_buffer.sv
// rtl/row_buffer.sv - two-bank ROWS x COLS occupancy array with registered pixel read
// Ports:
//   clk, rst                      clock, asynchronous active-high clear of both banks
//   i_wr_en/i_wr_bank/i_wr_row    write strobe, bank and row
//   i_wr_data                     row occupancy bits
//   i_rd_bank/i_rd_row/i_rd_col   pixel read address
//   o_rd_pix                      registered pixel, 0 when the address is off the board
module row_buffer #(
    parameter int ROWS = 20,
    parameter int COLS = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_wr_en,
    input  logic            i_wr_bank,
    input  logic [4:0]      i_wr_row,
    input  logic [COLS-1:0] i_wr_data,
    input  logic            i_rd_bank,
    input  logic [4:0]      i_rd_row,
    input  logic [3:0]      i_rd_col,
    output logic            o_rd_pix
);

    logic [COLS-1:0] r_mem [2][ROWS];
    logic            r_rd_pix;
    logic            w_wr_ok;
    logic            w_rd_ok;

    assign w_wr_ok = (32'(i_wr_row) < ROWS);
    assign w_rd_ok = (32'(i_rd_row) < ROWS) && (32'(i_rd_col) < COLS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    r_mem[b][r] <= '0;
                end
            end
        end else if (i_wr_en && w_wr_ok) begin
            r_mem[i_wr_bank][i_wr_row] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pix <= 1'b0;
        end else begin
            r_rd_pix <= w_rd_ok ? r_mem[i_rd_bank][i_rd_row][i_rd_col] : 1'b0;
        end
    end

    assign o_rd_pix = r_rd_pix;

endmodule

// File: rtl/board_row_snapshot.sv
// rtl/board_row_snapshot.sv - sweeps board rows via GET_ROW into a double-buffered shadow and flags full lines
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   start, busy, done           sweep request, sweep in progress, new frame visible pulse
//   row_req, row_idx, row_data  GET_ROW request/index to board memory, row word returned MEM_LAT later
//   rd_row, rd_col, rd_pix      display read of the front buffer, 1-cycle registered
//   full_mask, full_valid       filled-line mask of the last frame and its pending flag
//   full_ack                    controller consumed full_mask
//   frame_id                    toggles on every buffer swap
module board_row_snapshot #(
    parameter int ROWS    = 20,
    parameter int COLS    = 10,
    parameter int ROW_W   = 32,
    parameter int MEM_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             row_req,
    output logic [4:0]       row_idx,
    input  logic [ROW_W-1:0] row_data,
    input  logic [4:0]       rd_row,
    input  logic [3:0]       rd_col,
    output logic             rd_pix,
    output logic [ROWS-1:0]  full_mask,
    output logic             full_valid,
    input  logic             full_ack,
    output logic             frame_id
);

    import board_pkg::*;

    scan_state_t        r_state;
    scan_state_t        w_next;
    logic [4:0]         r_cnt;
    logic [MEM_LAT-1:0] r_pv;
    logic [4:0]         r_pidx [MEM_LAT];
    logic [ROWS-1:0]    r_mask_acc;
    logic [ROWS-1:0]    r_full_mask;
    logic               r_bank;
    logic               r_frame_id;
    logic               r_full_valid;
    logic               r_done;

    logic               w_row_req;
    logic               w_pipe_clear;
    logic               w_cap;
    logic [4:0]         w_cap_idx;
    logic [COLS-1:0]    w_cap_data;
    logic               w_line_full;
    logic               w_rd_bank;
    logic               w_back_bank;
    logic               w_unused_hi;

    // Tail entry of the request pipeline lines up with the memory's returned word.
    assign w_cap       = r_pv[MEM_LAT-1];
    assign w_cap_idx   = r_pidx[MEM_LAT-1];
    assign w_cap_data  = row_data[COLS-1:0];
    assign w_line_full = &w_cap_data;
    assign w_unused_hi = ^row_data[ROW_W-1:COLS];

    assign w_back_bank = ~r_bank;
    // The read registered at the SWAP edge already targets the new front bank,
    // so new-frame pixels appear in the same cycle as done.
    assign w_rd_bank   = (r_state == S_SWAP) ? ~r_bank : r_bank;

    // Only the tail may still be valid: it is written at this edge, so the
    // back buffer is complete by the time SWAP is entered.
    always_comb begin
        w_pipe_clear = 1'b1;
        for (int i = 0; i < MEM_LAT - 1; i++) begin
            if (r_pv[i]) begin
                w_pipe_clear = 1'b0;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_row_req = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_SCAN;
                end
            end
            S_SCAN: begin
                w_row_req = 1'b1;
                if (r_cnt == 5'(ROWS - 1)) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pipe_clear) begin
                    w_next = S_SWAP;
                end
            end
            S_SWAP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_mask_acc   <= '0;
            r_full_mask  <= '0;
            r_bank       <= 1'b0;
            r_frame_id   <= 1'b0;
            r_full_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == S_SWAP);

            if (r_state == S_IDLE && start) begin
                r_cnt      <= '0;
                r_mask_acc <= '0;
            end else begin
                if (r_state == S_SCAN) begin
                    r_cnt <= r_cnt + 5'd1;
                end
                if (w_cap) begin
                    r_mask_acc[w_cap_idx] <= w_line_full;
                end
            end

            // A publish beats a coincident acknowledge.
            if (r_state == S_SWAP) begin
                r_bank       <= ~r_bank;
                r_frame_id   <= ~r_frame_id;
                r_full_mask  <= r_mask_acc;
                r_full_valid <= 1'b1;
            end else if (full_ack) begin
                r_full_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pv <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                r_pidx[i] <= '0;
            end
        end else begin
            r_pv[0]   <= w_row_req;
            r_pidx[0] <= r_cnt;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_pv[i]   <= r_pv[i-1];
                r_pidx[i] <= r_pidx[i-1];
            end
        end
    end

    row_buffer #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_row_buffer (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_cap),
        .i_wr_bank (w_back_bank),
        .i_wr_row  (w_cap_idx),
        .i_wr_data (w_cap_data),
        .i_rd_bank (w_rd_bank),
        .i_rd_row  (rd_row),
        .i_rd_col  (rd_col),
        .o_rd_pix  (rd_pix)
    );

    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign row_req    = w_row_req;
    assign row_idx    = w_row_req ? r_cnt : 5'd0;
    assign full_mask  = r_full_mask;
    assign full_valid = r_full_valid;
    assign frame_id   = r_frame_id;

endmodule
